// File: rtl/disp_share_arb.sv
// disp_share_arb: round-robin arbiter sharing one 6-digit hex display among
// three requesters; the winner's 24-bit value is latched for a minimum dwell.
// Latency: 1 cycle from req sample to ack/disp_data update (all outputs registered).
// Backpressure: requesters hold req until ack; requests arriving mid-dwell wait
// for the dwell to end; a req dropped before ack is simply withdrawn.
//
// Ports:
//   sys_clk, sys_rst     clock (rising edge), async active-high reset
//   req[2:0]             level request per channel
//   data0/1/2[23:0]      per-channel display value, sampled on grant
//   ack[2:0]             one-cycle one-hot grant pulse
//   disp_data[23:0]      value for the display scan driver
//   disp_owner[1:0]      channel currently or last shown
//   disp_valid           set once anything has been granted since reset
//   busy                 high while a dwell is in progress
//
// Optional build macro: DISP_OWNER_TAG_EN -- when defined, the leftmost digit
// is replaced by A/B/C to identify channel 0/1/2.

module disp_share_arb #(
  parameter int NREQ     = 3,
  parameter int HOLD_CYC = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [NREQ-1:0] req,
  input  logic [23:0]     data0,
  input  logic [23:0]     data1,
  input  logic [23:0]     data2,
  output logic [NREQ-1:0] ack,
  output logic [23:0]     disp_data,
  output logic [1:0]      disp_owner,
  output logic            disp_valid,
  output logic            busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        last, last_nxt;
  logic [NREQ-1:0]   ack_nxt;
  logic [23:0]       disp_data_nxt;
  logic [1:0]        disp_owner_nxt;
  logic              disp_valid_nxt;
  logic              busy_nxt;

  // Arbitration signals
  logic              any_req;
  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        win;
  logic [23:0]       sel_data;
  logic [23:0]       grant_data;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts just after the last winner and wraps, so the last
  // winner is considered only when nobody else is asking.
  always_comb begin
    any_req = |req;
    cand0   = next_idx(last);
    cand1   = next_idx(cand0);
    cand2   = last;
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else                 win = cand2;
  end

  always_comb begin
    case (win)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      default: sel_data = data2;
    endcase
  end

`ifdef DISP_OWNER_TAG_EN
  // Leftmost digit becomes A/B/C so the viewer can tell who owns the display.
  assign grant_data = {4'hA + {2'b00, win}, sel_data[19:0]};
`else
  assign grant_data = sel_data;
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_nxt       = last;
    ack_nxt        = '0;
    disp_data_nxt  = disp_data;
    disp_owner_nxt = disp_owner;
    disp_valid_nxt = disp_valid;
    busy_nxt       = busy;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt      = HOLD;
          cnt_nxt        = '0;
          last_nxt       = win;
          ack_nxt[win]   = 1'b1;
          disp_data_nxt  = grant_data;
          disp_owner_nxt = win;
          disp_valid_nxt = 1'b1;
          busy_nxt       = 1'b1;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          // Dwell complete: re-arbitrate on the same edge so a waiting
          // channel lands without an idle gap.
          if (any_req) begin
            state_nxt      = HOLD;
            cnt_nxt        = '0;
            last_nxt       = win;
            ack_nxt[win]   = 1'b1;
            disp_data_nxt  = grant_data;
            disp_owner_nxt = win;
            disp_valid_nxt = 1'b1;
            busy_nxt       = 1'b1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 2'd2;  // channel 0 wins the first arbitration
      ack        <= '0;
      disp_data  <= 24'h000000;
      disp_owner <= 2'd0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last       <= last_nxt;
      ack        <= ack_nxt;
      disp_data  <= disp_data_nxt;
      disp_owner <= disp_owner_nxt;
      disp_valid <= disp_valid_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Testbench for disp_share_arb: one instance with a 4-cycle dwell and one with
// a 1-cycle dwell, sharing clock, reset and request inputs.
module tb_disp_share_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [23:0] data0, data1, data2;

  logic [2:0]  ack,  ack1;
  logic [23:0] disp_data, disp_data1;
  logic [1:0]  disp_owner, disp_owner1;
  logic        disp_valid, disp_valid1;
  logic        busy, busy1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  owner;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 sys_clk = ~sys_clk;

  disp_share_arb #(.NREQ(3), .HOLD_CYC(4), .CNT_W(26)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .disp_data(disp_data), .disp_owner(disp_owner),
    .disp_valid(disp_valid), .busy(busy)
  );

  disp_share_arb #(.NREQ(3), .HOLD_CYC(1), .CNT_W(26)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack1), .disp_data(disp_data1), .disp_owner(disp_owner1),
    .disp_valid(disp_valid1), .busy(busy1)
  );

  // Expected display value for a grant to channel w carrying value d.
  function automatic logic [23:0] exp_disp(input logic [1:0] w, input logic [23:0] d);
`ifdef DISP_OWNER_TAG_EN
    return {4'hA + {2'b00, w}, d[19:0]};
`else
    return d;
`endif
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    req     = 3'b000;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req = 3'b000; data0 = 24'h0; data1 = 24'h0; data2 = 24'h0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({ack, disp_data, disp_owner, disp_valid, busy} !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b data=%h own=%0d vld=%b busy=%b exp all zero",
               ack, disp_data, disp_owner, disp_valid, busy);
    end
    checks++;
    if ({ack1, disp_data1, disp_owner1, disp_valid1, busy1} !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs_h1 got ack=%b data=%h own=%0d vld=%b busy=%b exp all zero",
               ack1, disp_data1, disp_owner1, disp_valid1, busy1);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge sys_clk);
    data1 = 24'h123456;
    req   = 3'b010;
    sb.push_back('{owner: 2'd1, data: exp_disp(2'd1, 24'h123456)});
    @(negedge sys_clk);
    req = 3'b000;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL single_sb_empty got empty queue exp one entry");
    end else begin
      e = sb.pop_front();
      if ({ack, disp_owner, disp_data, disp_valid, busy} !== {3'b010, e.owner, e.data, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL single_grant got ack=%b own=%0d data=%h vld=%b busy=%b exp ack=010 own=%0d data=%h vld=1 busy=1",
                 ack, disp_owner, disp_data, disp_valid, busy, e.owner, e.data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({ack, busy} !== {3'b000, 1'b1}) begin
        failures++;
        $display("FAIL single_dwell[%0d] got ack=%b busy=%b exp ack=000 busy=1", i, ack, busy);
      end
    end
    @(negedge sys_clk);
    checks++;
    if ({busy, disp_data, disp_owner, disp_valid} !== {1'b0, exp_disp(2'd1, 24'h123456), 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_end got busy=%b data=%h own=%0d vld=%b exp busy=0 data=%h own=1 vld=1",
               busy, disp_data, disp_owner, disp_valid, exp_disp(2'd1, 24'h123456));
    end
  endtask

  task automatic test_all_three();
    exp_t e;
    int   last_t;
    int   n;
    do_reset();
    data0 = 24'h000001; data1 = 24'h000002; data2 = 24'h000003;
    for (int k = 0; k < 6; k++)
      sb.push_back('{owner: 2'(k % 3), data: exp_disp(2'(k % 3), 24'(k % 3 + 1))});
    req = 3'b111;
    last_t = 0;
    n = 0;
    for (int t = 0; t < 40 && sb.size() != 0; t++) begin
      @(negedge sys_clk);
      checks++;
      if (!$onehot0(ack)) begin
        failures++; $display("FAIL rr_onehot got ack=%b exp at most one bit", ack);
      end
      if (ack != 3'b000) begin
        e = sb.pop_front();
        checks++;
        if ({ack, disp_owner, disp_data} !== {3'b001 << e.owner, e.owner, e.data}) begin
          failures++;
          $display("FAIL rr_grant[%0d] got ack=%b own=%0d data=%h exp own=%0d data=%h",
                   n, ack, disp_owner, disp_data, e.owner, e.data);
        end
        checks++;
        if ((n == 0 && t != 0) || (n > 0 && t - last_t != 4)) begin
          failures++;
          $display("FAIL rr_spacing[%0d] got t=%0d prev=%0d exp gap 4", n, t, last_t);
        end
        last_t = t;
        n++;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL rr_timeout got %0d grants missing exp 0", sb.size());
    end
    req = 3'b000;
  endtask

  task automatic test_frozen();
    exp_t e;
    logic [23:0] held;
    int          done;
    do_reset();
    // Part 1: a short req[0] pulse mid-dwell is ignored and lost.
    data1 = 24'h0B0B0B;
    req   = 3'b010;
    sb.push_back('{owner: 2'd1, data: exp_disp(2'd1, 24'h0B0B0B)});
    held = exp_disp(2'd1, 24'h0B0B0B);
    @(negedge sys_clk);
    req = 3'b000;
    e = sb.pop_front();
    checks++;
    if ({ack, disp_owner, disp_data} !== {3'b010, e.owner, e.data}) begin
      failures++;
      $display("FAIL frozen_grant got ack=%b own=%0d data=%h exp ack=010 own=1 data=%h",
               ack, disp_owner, disp_data, e.data);
    end
    @(negedge sys_clk);
    data0 = 24'h111111;
    req   = 3'b001;
    @(negedge sys_clk);
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ack, disp_data} !== {3'b000, held}) begin
        failures++;
        $display("FAIL frozen_hold[%0d] got ack=%b data=%h exp ack=000 data=%h", i, ack, disp_data, held);
      end
      @(negedge sys_clk);
    end
    checks++;
    if ({busy, disp_owner, disp_data, ack} !== {1'b0, 2'd1, held, 3'b000}) begin
      failures++;
      $display("FAIL frozen_idle got busy=%b own=%0d data=%h ack=%b exp busy=0 own=1 data=%h ack=000",
               busy, disp_owner, disp_data, ack, held);
    end
    // Part 2: req[0] held through the dwell is granted exactly at dwell end.
    req = 3'b010;
    sb.push_back('{owner: 2'd1, data: held});
    @(negedge sys_clk);
    e = sb.pop_front();
    checks++;
    if ({ack, disp_data} !== {3'b010, e.data}) begin
      failures++;
      $display("FAIL frozen_regrant got ack=%b data=%h exp ack=010 data=%h", ack, disp_data, e.data);
    end
    req   = 3'b001;
    data0 = 24'h222222;
    sb.push_back('{owner: 2'd0, data: exp_disp(2'd0, 24'h222222)});
    done = 0;
    for (int t = 1; t <= 10 && done == 0; t++) begin
      @(negedge sys_clk);
      if (ack == 3'b000) begin
        checks++;
        if (disp_data !== held) begin
          failures++; $display("FAIL frozen_wait[%0d] got data=%h exp %h", t, disp_data, held);
        end
      end else begin
        e = sb.pop_front();
        done = 1;
        checks++;
        if ({t[3:0], ack, disp_owner, disp_data} !== {4'd4, 3'b001, e.owner, e.data}) begin
          failures++;
          $display("FAIL frozen_next got t=%0d ack=%b own=%0d data=%h exp t=4 ack=001 own=0 data=%h",
                   t, ack, disp_owner, disp_data, e.data);
        end
      end
    end
    checks++;
    if (done == 0) begin
      failures++; $display("FAIL frozen_timeout got no grant exp grant to channel 0");
    end
    req = 3'b000;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    data0 = 24'h000001; data1 = 24'h000002; data2 = 24'h000003;
    req = 3'b111;
    sb.push_back('{owner: 2'd0, data: exp_disp(2'd0, 24'h000001)});
    @(negedge sys_clk);
    e = sb.pop_front();
    checks++;
    if ({ack, disp_owner, disp_data} !== {3'b001, e.owner, e.data}) begin
      failures++;
      $display("FAIL midrst_grant got ack=%b own=%0d data=%h exp ack=001 own=0 data=%h",
               ack, disp_owner, disp_data, e.data);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({ack, disp_data, disp_owner, disp_valid, busy} !== 31'd0) begin
      failures++;
      $display("FAIL midrst_async got ack=%b data=%h own=%0d vld=%b busy=%b exp all zero",
               ack, disp_data, disp_owner, disp_valid, busy);
    end
    @(negedge sys_clk);
    checks++;
    if ({ack, busy, disp_valid} !== 5'd0) begin
      failures++; $display("FAIL midrst_held got ack=%b busy=%b vld=%b exp zero", ack, busy, disp_valid);
    end
    sys_rst = 1'b0;
    sb.push_back('{owner: 2'd0, data: exp_disp(2'd0, 24'h000001)});
    @(negedge sys_clk);
    e = sb.pop_front();
    checks++;
    if ({ack, disp_owner, disp_data, busy} !== {3'b001, e.owner, e.data, 1'b1}) begin
      failures++;
      $display("FAIL midrst_after got ack=%b own=%0d data=%h busy=%b exp ack=001 own=0 data=%h busy=1",
               ack, disp_owner, disp_data, busy, e.data);
    end
    req = 3'b000;
  endtask

  task automatic test_hold1();
    exp_t e;
    do_reset();
    data0 = 24'h00000A; data2 = 24'h00000C;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) sb.push_back('{owner: 2'd0, data: exp_disp(2'd0, 24'h00000A)});
      else            sb.push_back('{owner: 2'd2, data: exp_disp(2'd2, 24'h00000C)});
    end
    req = 3'b101;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      e = sb.pop_front();
      checks++;
      if ({ack1, disp_owner1, disp_data1, busy1} !== {3'b001 << e.owner, e.owner, e.data, 1'b1}) begin
        failures++;
        $display("FAIL hold1[%0d] got ack=%b own=%0d data=%h busy=%b exp own=%0d data=%h busy=1",
                 i, ack1, disp_owner1, disp_data1, busy1, e.owner, e.data);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_tag();
    logic [23:0] want;
`ifdef DISP_OWNER_TAG_EN
    want = 24'hC87654;
`else
    want = 24'h987654;
`endif
    do_reset();
    data2 = 24'h987654;
    req   = 3'b100;
    @(negedge sys_clk);
    req = 3'b000;
    checks++;
    if ({ack, disp_owner, disp_data} !== {3'b100, 2'd2, want}) begin
      failures++;
      $display("FAIL tag got ack=%b own=%0d data=%h exp ack=100 own=2 data=%h",
               ack, disp_owner, disp_data, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_frozen();
    test_mid_reset();
    test_hold1();
    test_tag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Round-robin arbiter that shares the single 6-digit hex seven-segment display between three requesters (e.g. I2C read-back value, event counter, status/error code).
- Each requester presents a 24-bit value (6 hex nibbles). On grant, the winner's value is latched onto the display bus for a guaranteed minimum dwell time.
- Sits between the requesting blocks and the display scan driver, whose DATA input takes disp_data directly.

Parameters:
- NREQ, 3, number of requesters; fixed at 3, not intended for override.
- HOLD_CYC, 50_000_000, minimum dwell in sys_clk cycles per grant (1 s at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 26, width of the dwell counter.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
- req  in  3  level request per channel; held high until the matching ack.
- data0  in  24  channel 0 display value, sampled on grant.
- data1  in  24  channel 1 display value.
- data2  in  24  channel 2 display value.
- ack  out  3  one-cycle grant pulse, one-hot, registered.
- disp_data  out  24  value driven to the display driver, registered.
- disp_owner  out  2  index of the channel currently or last shown.
- disp_valid  out  1  high once any value has been granted since reset.
- busy  out  1  high while a dwell is in progress (HOLD state).

Behaviour:
- Reset values (async, while sys_rst=1):
  - disp_data=24'h000000, disp_owner=2'd0, disp_valid=0, ack=3'b000, busy=0.
  - State=IDLE, dwell counter=0, round-robin pointer last=2'd2, so channel 0 wins the first arbitration.
- Arbitration is combinational over req. The search starts at last+1 modulo 3 and wraps; channel `last` is checked last.
- IDLE:
  - If req==0: remain in IDLE. disp_data and disp_owner hold their last value; disp_valid is unchanged.
  - If any req bit is set in cycle N: at edge N+1, for winner w:
    - disp_data<=data_w, disp_owner<=w, last<=w, ack[w]<=1 (one cycle only), disp_valid<=1.
    - busy<=1, counter<=0, state<=HOLD.
  - Latency from req sample to ack/disp_data update is 1 cycle.
- HOLD:
  - Counter increments by 1 each cycle. disp_data is frozen; data changes and new req from any channel (including the owner) are ignored.
  - When counter==HOLD_CYC-1:
    - If any req is set, re-arbitrate exactly as in IDLE, in the same edge. The new grant takes effect at the next edge, busy stays 1, and the counter restarts at 0.
    - Otherwise go to IDLE with busy<=0; the display keeps showing the last value.
- Dwell length per grant: exactly HOLD_CYC cycles of busy=1 before the next grant can land.
- HOLD_CYC=1: back-to-back grants every cycle are possible.
- Requester that keeps req high after its ack: treated as a fresh request. It is served again only after the other pending channels (round-robin fairness).
- req dropped before ack: the request is withdrawn with no grant; there is no error.
- Simultaneous requests: exactly one ack per grant edge. ack is never multi-hot.
- Reset asserted mid-dwell: immediate return to reset values. No ack is emitted until after reset is released and a new arbitration occurs.
- Counter never exceeds HOLD_CYC-1; there is no wrap within CNT_W.

Optional Feature:
- Macro DISP_OWNER_TAG_EN.
- Defined: on grant, disp_data[23:20] <= 4'hA + w, so the leftmost digit shows A/B/C for channels 0/1/2. data_w[23:20] is discarded; disp_data[19:0] = data_w[19:0].
- Undefined: disp_data = data_w, all 24 bits unchanged.
- Reset value is 24'h000000 in both builds.

Test Plan:
- Reset then single request: reset, HOLD_CYC=4, req=3'b010 with data1=24'h123456 at cycle 0 -> at edge 1: ack=3'b010 (1 cycle), disp_data=24'h123456, disp_owner=1, busy=1. busy stays high 4 cycles, then returns to 0 with disp_data held.
- All three requesting: req=3'b111 held, data0/1/2=24'h000001/24'h000002/24'h000003 -> grants in order 0,1,2,0,… every 4 cycles; ack is strictly one-hot; disp_data follows 1,2,3,1.
- Frozen during dwell: during HOLD, change data0 and pulse req[0] while channel 1 owns the display -> disp_data is unchanged until the dwell ends. Channel 0 is granted next only if req[0] is still high at dwell end.
- Mid-dwell reset: pulse sys_rst for 1 cycle at dwell cycle 2 -> outputs return immediately to 0/000000/0. Next grant after release goes to channel 0 when req=3'b111.
- HOLD_CYC=1: req=3'b101 held -> acks alternate 001,100,001,… on consecutive cycles.
- With DISP_OWNER_TAG_EN: grant channel 2 with data2=24'h987654 -> disp_data=24'hC87654. Without the macro -> disp_data=24'h987654.
